// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: prefix bytes, dropped control bytes and
// the frame FSM state encoding used by the keyboard and mouse receivers.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    // BAT ok, ACK, echo, resend, overrun (two encodings)
    localparam int PS2_NDROP = 6;
    localparam logic [PS2_NDROP-1:0][7:0] PS2_DROP_LIST =
        {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    function automatic logic ps2_is_drop(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < PS2_NDROP; i++) begin
            if (b == PS2_DROP_LIST[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for the PS/2 clock and data lines plus falling-edge
// detect on the synchronised clock.
module ps2_sync_edge (
    input  logic clk_sys,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fall
);
    import ps2_pkg::*;

    logic [1:0] clk_sync_q, clk_sync_d;
    logic [1:0] data_sync_q, data_sync_d;
    logic       clk_prev_q, clk_prev_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        clk_prev_d  = clk_sync_q[1];
    end

    // Reset to the idle-high line level so leaving reset never fakes a fall.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign data_s = data_sync_q[1];
    assign fall   = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames and folds E0/F0/E1 prefixes
// into single-cycle key events for the keyboard matrix mapper.
module ps2_kbd_rx #(
    parameter int TIMEOUT = 2048
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic [7:0] key_code,
    output logic       key_pressed,
    output logic       key_extended,
    output logic       rx_error
);
    import ps2_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);

    logic data_s;
    logic fall;

    ps2_sync_edge u_sync (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_s   (data_s),
        .fall     (fall)
    );

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          byte_ok_q, byte_ok_d;
    logic          byte_err_q, byte_err_d;
    logic          ext_q, ext_d;
    logic          rel_q, rel_d;
    logic [2:0]    skip_cnt_q, skip_cnt_d;
    logic          key_strobe_q, key_strobe_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_pressed_q, key_pressed_d;
    logic          key_extended_q, key_extended_d;
    logic          rx_error_q, rx_error_d;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_byte_d      = rx_byte_q;
        parity_d       = parity_q;
        tmo_cnt_d      = tmo_cnt_q;
        byte_ok_d      = 1'b0;
        byte_err_d     = 1'b0;
        ext_d          = ext_q;
        rel_d          = rel_q;
        skip_cnt_d     = skip_cnt_q;
        key_strobe_d   = 1'b0;
        key_code_d     = key_code_q;
        key_pressed_d  = key_pressed_q;
        key_extended_d = key_extended_q;
        rx_error_d     = 1'b0;

        if (state_q == ST_IDLE || fall) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TW'(TIMEOUT)) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end

        // Frame stage: results are staged one cycle in byte_ok/byte_err.
        if (state_q != ST_IDLE && tmo_cnt_q == TW'(TIMEOUT)) begin
            byte_err_d = 1'b1;
            state_d    = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        byte_err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    rx_byte_d = {data_s, rx_byte_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_d = data_s;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    if (data_s && (^{rx_byte_q, parity_q})) byte_ok_d  = 1'b1;
                    else                                   byte_err_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Event stage: prefix folding and output registers.
        if (byte_err_q) begin
            rx_error_d = 1'b1;
            ext_d      = 1'b0;
            rel_d      = 1'b0;
        end else if (byte_ok_q) begin
            if (skip_cnt_q != 3'd0) begin
                skip_cnt_d = skip_cnt_q - 3'd1;
            end else if (rx_byte_q == PS2_PFX_PAUSE) begin
                skip_cnt_d = 3'd7;
            end else if (rx_byte_q == PS2_PFX_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte_q == PS2_PFX_REL) begin
                rel_d = 1'b1;
            end else if (!ext_q && !rel_q && ps2_is_drop(rx_byte_q)) begin
                skip_cnt_d = skip_cnt_q;
            end else begin
                key_strobe_d   = 1'b1;
                key_code_d     = rx_byte_q;
                key_pressed_d  = ~rel_q;
                key_extended_d = ext_q;
                ext_d          = 1'b0;
                rel_d          = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= 3'd0;
            rx_byte_q      <= 8'd0;
            parity_q       <= 1'b0;
            tmo_cnt_q      <= '0;
            byte_ok_q      <= 1'b0;
            byte_err_q     <= 1'b0;
            ext_q          <= 1'b0;
            rel_q          <= 1'b0;
            skip_cnt_q     <= 3'd0;
            key_strobe_q   <= 1'b0;
            key_code_q     <= 8'd0;
            key_pressed_q  <= 1'b0;
            key_extended_q <= 1'b0;
            rx_error_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_byte_q      <= rx_byte_d;
            parity_q       <= parity_d;
            tmo_cnt_q      <= tmo_cnt_d;
            byte_ok_q      <= byte_ok_d;
            byte_err_q     <= byte_err_d;
            ext_q          <= ext_d;
            rel_q          <= rel_d;
            skip_cnt_q     <= skip_cnt_d;
            key_strobe_q   <= key_strobe_d;
            key_code_q     <= key_code_d;
            key_pressed_q  <= key_pressed_d;
            key_extended_q <= key_extended_d;
            rx_error_q     <= rx_error_d;
        end
    end

    assign key_strobe   = key_strobe_q;
    assign key_code     = key_code_q;
    assign key_pressed  = key_pressed_q;
    assign key_extended = key_extended_q;
    assign rx_error     = rx_error_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: directed PS/2 frames at clk_sys/200,
// expected key events / errors queued and checked by an independent monitor.
module tb_ps2_kbd_rx;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_pressed;
    logic       key_extended;
    logic       rx_error;

    ps2_kbd_rx #(.TIMEOUT(2048)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_strobe   (key_strobe),
        .key_code     (key_code),
        .key_pressed  (key_pressed),
        .key_extended (key_extended),
        .rx_error     (rx_error)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         pressed;
        bit         ext;
        bit         chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   stop_cyc = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic exp_key(input logic [7:0] code, input bit pressed, input bit ext);
        exp_t e;
        e.is_err = 1'b0; e.code = code; e.pressed = pressed; e.ext = ext; e.chk_lat = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic exp_err(input bit chk_lat);
        exp_t e;
        e.is_err = 1'b1; e.code = 8'h00; e.pressed = 1'b0; e.ext = 1'b0; e.chk_lat = chk_lat;
        exp_q.push_back(e);
    endtask

    // Sends the first nbits bits of a frame; data changes while ps2_clk is high.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            wait_cyc(50);
            ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc + 1;
            wait_cyc(100);
            ps2_clk = 1'b1;
            wait_cyc(50);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_strobe"},   int'(key_strobe),   0);
        check({tag, "_code"},     int'(key_code),     0);
        check({tag, "_pressed"},  int'(key_pressed),  0);
        check({tag, "_extended"}, int'(key_extended), 0);
        check({tag, "_error"},    int'(rx_error),     0);
    endtask

    always @(negedge clk_sys) begin
        exp_t e;
        if (!reset && (key_strobe || rx_error)) begin
            if (key_strobe && rx_error) check("strobe_error_same_cycle", 1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", int'(key_strobe) * 2 + int'(rx_error), 0);
            end else begin
                e = exp_q.pop_front();
                check("event_is_error", int'(rx_error), int'(e.is_err));
                if (!e.is_err) begin
                    check("key_code",     int'(key_code),     int'(e.code));
                    check("key_pressed",  int'(key_pressed),  int'(e.pressed));
                    check("key_extended", int'(key_extended), int'(e.ext));
                end
                if (e.chk_lat) check("latency", cyc - stop_cyc, 3);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, %0d events still pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        wait_cyc(5);
        check_outputs_zero("reset");
        reset = 1'b0;
        wait_cyc(20);

        // 1: plain make code
        exp_key(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C);
        wait_cyc(20);

        // 2: extended break
        exp_key(8'h75, 1'b0, 1'b1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        wait_cyc(20);

        // 3: parity error, then recovery
        exp_err(1'b1);
        send_frame(8'h1C, 1'b1, 11);
        exp_key(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C);
        wait_cyc(20);

        // 4: timeout mid-frame clears pending F0
        send_byte(8'hF0);
        exp_err(1'b0);
        send_frame(8'h29, 1'b0, 5);
        wait_cyc(2300);
        exp_key(8'h29, 1'b1, 1'b0);
        send_byte(8'h29);
        wait_cyc(20);

        // 5: Pause sequence swallowed
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        exp_key(8'h5A, 1'b1, 1'b0);
        send_byte(8'h5A);
        wait_cyc(20);

        // 6: dropped control bytes, reset mid-frame
        send_byte(8'hAA);
        send_byte(8'hFA);
        send_frame(8'h16, 1'b0, 3);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        check_outputs_zero("midframe_reset");
        wait_cyc(300);
        exp_key(8'h16, 1'b1, 1'b0);
        send_byte(8'h16);

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) wait_cyc(1);
        wait_cyc(50);
        check("events_pending_at_end", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
